// File: rtl/bsg_accumulator_carry_save.sv
// rtl/bsg_accumulator_carry_save.sv - carry-save stream accumulator with one resolving add per group
module bsg_accumulator_carry_save #(
  parameter int width_p     = 32,
  parameter int max_beats_p = 16,
  localparam int cnt_w      = ($clog2(max_beats_p + 1) < 1) ? 1 : $clog2(max_beats_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  input  logic               last_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  output logic [cnt_w-1:0]   count_o,
  input  logic               yumi_i
);

  typedef enum logic [1:0] {eAccum, eResolve, eDone} state_e;

  state_e             state_r;
  logic [width_p-1:0] sum_r;
  logic [width_p-1:0] carry_r;
  logic [width_p-1:0] data_r;
  logic [cnt_w-1:0]   cnt_r;

  logic               accept;
  logic [width_p-1:0] maj;

  assign ready_o = (state_r == eAccum);
  assign v_o     = (state_r == eDone);
  assign data_o  = data_r;
  assign count_o = cnt_r;

  assign accept = v_i & ready_o;
  // Shifting the majority left drops the MSB carry, which keeps the pair modulo 2^width_p.
  assign maj    = (data_i & sum_r) | (data_i & carry_r) | (sum_r & carry_r);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= eAccum;
      sum_r   <= '0;
      carry_r <= '0;
      data_r  <= '0;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        eAccum: begin
          if (accept) begin
            sum_r   <= data_i ^ sum_r ^ carry_r;
            carry_r <= maj << 1;
            if (cnt_r != cnt_w'(max_beats_p)) begin
              cnt_r <= cnt_r + 1'b1;
            end
            if (last_i) begin
              state_r <= eResolve;
            end
          end
        end
        eResolve: begin
          data_r  <= sum_r + carry_r;
          sum_r   <= '0;
          carry_r <= '0;
          state_r <= eDone;
        end
        eDone: begin
          if (yumi_i) begin
            state_r <= eAccum;
            cnt_r   <= '0;
          end
        end
        default: state_r <= eAccum;
      endcase
    end
  end

  // The consumer may only take a result that is being offered.
  yumi_only_when_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule
